// File: rtl/controle_estacionamento.sv
// Parking-lot gate controller: synchronizes and debounces the entry/exit sensors,
// tracks the vehicle count and drives the lot status lamps from a small FSM.
//
// state    | meaning
// OCIOSO   | lot has room, entry gate clear
// PASSAGEM | vehicle standing on the entry sensor
// LOTADO   | count at capacity
// ERRO     | sequence violation, held until both sensors are low
module controle_estacionamento #(
    parameter int CAPACIDADE = 9,
    parameter int FILTRO     = 3
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       SensorEntrada,
    input  logic       SensorSaida,
    output logic       Livre,
    output logic       Pare,
    output logic       Erro,
    output logic       Full,
    output logic [3:0] Contagem
);

    localparam int            CW  = $clog2(FILTRO + 1);
    localparam logic [CW-1:0] LIM = CW'(FILTRO - 1);
    localparam logic [3:0]    CAP = 4'(CAPACIDADE);

    typedef enum logic [1:0] {OCIOSO, PASSAGEM, LOTADO, ERRO} estado_t;

    estado_t       estado, estado_nx;
    logic [3:0]    contagem_nx;
    logic          falha;

    // bit 0 = entry sensor, bit 1 = exit sensor
    logic [1:0]    sinc1, sinc2, deb, deb_d;
    logic [CW-1:0] cnt [2];
    logic [1:0]    evento;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sinc1  <= '0;
            sinc2  <= '0;
            deb    <= '0;
            deb_d  <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sinc1 <= {SensorSaida, SensorEntrada};
            sinc2 <= sinc1;
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sinc2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LIM) begin
                    deb[i] <= sinc2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign evento = deb & ~deb_d;

    always_comb begin
        estado_nx   = estado;
        contagem_nx = Contagem;
        falha       = 1'b0;
        if (estado == ERRO) begin
            // counting is frozen; the lot leaves ERRO only once both gates are clear
            if (deb == 2'b00) begin
                estado_nx = (Contagem == CAP) ? LOTADO : OCIOSO;
            end
        end else begin
            case (evento)
                2'b01: begin
                    if (Contagem < CAP) contagem_nx = Contagem + 4'd1;
                    else                falha       = 1'b1;
                end
                2'b10: begin
                    if (Contagem != 4'd0) contagem_nx = Contagem - 4'd1;
                    else                  falha       = 1'b1;
                end
                default: ;
            endcase
            if (falha)                    estado_nx = ERRO;
            else if (contagem_nx == CAP)  estado_nx = LOTADO;
            else if (deb[0])              estado_nx = PASSAGEM;
            else                          estado_nx = OCIOSO;
        end
    end

    // outputs are decoded from the next state so they change on the same edge as the state
    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado   <= OCIOSO;
            Contagem <= 4'd0;
            Livre    <= 1'b1;
            Pare     <= 1'b0;
            Erro     <= 1'b0;
            Full     <= 1'b0;
        end else begin
            estado   <= estado_nx;
            Contagem <= contagem_nx;
            Livre    <= (estado_nx == OCIOSO);
            Pare     <= (estado_nx != OCIOSO);
            Erro     <= (estado_nx == ERRO);
            Full     <= (estado_nx == LOTADO);
        end
    end

endmodule

// File: tb/tb_controle_estacionamento.sv
// Bench for controle_estacionamento: directed scenarios plus random sensor traffic,
// every cycle compared against a run-length reference model of the lot.
module tb_controle_estacionamento;

    localparam int CAP = 3;
    localparam int F   = 3;

    logic       Clock = 1'b0;
    logic       Reset, SensorEntrada, SensorSaida;
    logic       Livre, Pare, Erro, Full;
    logic [3:0] Contagem;

    int checks = 0;
    int errors = 0;

    controle_estacionamento #(.CAPACIDADE(CAP), .FILTRO(F)) dut (
        .Clock(Clock), .Reset(Reset),
        .SensorEntrada(SensorEntrada), .SensorSaida(SensorSaida),
        .Livre(Livre), .Pare(Pare), .Erro(Erro), .Full(Full),
        .Contagem(Contagem)
    );

    always #5 Clock = ~Clock;

    // reference model: raw sample history, debounced levels, count, error flag
    logic [1:0] h [F+2];
    logic [1:0] m_deb, m_deb_d;
    int         m_cnt;
    bit         m_err;
    bit         m_valid = 0;
    logic       x_livre, x_pare, x_erro, x_full;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic se, input logic ss);
        logic [1:0] ev;
        bit         stable;
        if (r) begin
            m_cnt = 0; m_err = 0; m_deb = '0; m_deb_d = '0;
            for (int i = 0; i < F + 2; i++) h[i] = '0;
        end else begin
            ev = m_deb & ~m_deb_d;
            if (m_err) begin
                if (m_deb == 2'b00) m_err = 0;
            end else if (ev == 2'b01) begin
                if (m_cnt < CAP) m_cnt++; else m_err = 1;
            end else if (ev == 2'b10) begin
                if (m_cnt > 0) m_cnt--; else m_err = 1;
            end
            // lamps chosen from the debounced entry level as seen before this edge
            x_erro  = m_err;
            x_full  = !m_err && (m_cnt == CAP);
            x_pare  = m_err || (m_cnt == CAP) || m_deb[0];
            x_livre = !x_pare;
            m_deb_d = m_deb;
            for (int i = F + 1; i > 0; i--) h[i] = h[i-1];
            h[0] = {ss, se};
            // a sensor flips once its synchronized level has disagreed for F samples in a row
            for (int k = 0; k < 2; k++) begin
                stable = 1;
                for (int j = 2; j < F + 2; j++) if (h[j][k] == m_deb[k]) stable = 0;
                if (stable) m_deb[k] = ~m_deb[k];
            end
            return;
        end
        x_livre = 1; x_pare = 0; x_erro = 0; x_full = 0;
    endtask

    task automatic cycle(input logic r, input logic se, input logic ss);
        Reset = r; SensorEntrada = se; SensorSaida = ss;
        @(posedge Clock);
        model_edge(r, se, ss);
        if (r) m_valid = 1;
        @(negedge Clock);
        if (m_valid) begin
            chk("livre", int'(Livre), int'(x_livre));
            chk("pare", int'(Pare), int'(x_pare));
            chk("erro", int'(Erro), int'(x_erro));
            chk("full", int'(Full), int'(x_full));
            chk("contagem", int'(Contagem), m_cnt);
        end
    endtask

    task automatic run(input int n, input logic r, input logic se, input logic ss);
        for (int i = 0; i < n; i++) cycle(r, se, ss);
    endtask

    initial begin
        int  hold;
        logic se, ss, rr;

        // reset state
        run(2, 1, 0, 0);
        chk("rst_livre", int'(Livre), 1);
        chk("rst_pare", int'(Pare), 0);
        chk("rst_erro", int'(Erro), 0);
        chk("rst_full", int'(Full), 0);
        chk("rst_contagem", int'(Contagem), 0);

        // single entry: count moves on the sixth edge of a held pulse
        run(5, 0, 1, 0);
        chk("entry_latency_before", int'(Contagem), 0);
        run(1, 0, 1, 0);
        chk("entry_count", int'(Contagem), 1);
        chk("entry_pare", int'(Pare), 1);
        chk("entry_livre", int'(Livre), 0);
        run(4, 0, 1, 0);
        run(6, 0, 0, 0);
        chk("entry_release_livre", int'(Livre), 1);
        chk("entry_release_count", int'(Contagem), 1);

        // glitch shorter than the filter
        run(2, 0, 1, 0);
        run(8, 0, 0, 0);
        chk("glitch_count", int'(Contagem), 1);
        chk("glitch_livre", int'(Livre), 1);

        // fill the lot, then overfill
        repeat (2) begin run(8, 0, 1, 0); run(8, 0, 0, 0); end
        chk("full_count", int'(Contagem), 3);
        chk("full_full", int'(Full), 1);
        chk("full_pare", int'(Pare), 1);
        run(8, 0, 1, 0);
        chk("over_erro", int'(Erro), 1);
        chk("over_full", int'(Full), 0);
        chk("over_count", int'(Contagem), 3);
        run(8, 0, 0, 0);
        chk("over_clear_full", int'(Full), 1);
        chk("over_clear_erro", int'(Erro), 0);

        // empty the lot, then underflow
        repeat (3) begin run(8, 0, 0, 1); run(8, 0, 0, 0); end
        chk("empty_count", int'(Contagem), 0);
        run(8, 0, 0, 1);
        chk("under_erro", int'(Erro), 1);
        chk("under_count", int'(Contagem), 0);
        run(8, 0, 0, 0);
        run(8, 0, 1, 0); run(8, 0, 0, 0);
        run(8, 0, 1, 1);
        chk("both_count", int'(Contagem), 1);
        chk("both_erro", int'(Erro), 0);
        run(8, 0, 0, 0);

        // reset lands inside a held entry pulse that ends right after it
        run(2, 0, 1, 0);
        run(2, 1, 1, 0);
        run(10, 0, 0, 0);
        chk("rst_pulse_count", int'(Contagem), 0);
        chk("rst_pulse_livre", int'(Livre), 1);
        run(8, 0, 1, 0);
        chk("rst_reassert_count", int'(Contagem), 1);
        run(8, 0, 0, 0);

        // random traffic
        hold = 0; se = 0; ss = 0;
        for (int n = 0; n < 1500; n++) begin
            if (hold == 0) begin
                se   = 1'($urandom_range(0, 1));
                ss   = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 9);
            end
            hold--;
            rr = ($urandom_range(0, 199) == 0);
            cycle(rr, se, ss);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_estacionamento.md
CONTROLE_ESTACIONAMENTO -- requirements
Module: controle_estacionamento

Interface
REQ-001 SHALL have parameter CAPACIDADE, default 9, maximum vehicle count (1..15).
REQ-002 SHALL have parameter FILTRO, default 3, debounce stability length in cycles (>=2).
REQ-003 SHALL have port Clock, input, 1, single system clock; all state updates on rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port SensorEntrada, input, 1, raw asynchronous entry-gate sensor, high = vehicle present.
REQ-006 SHALL have port SensorSaida, input, 1, raw asynchronous exit-gate sensor, high = vehicle present.
REQ-007 SHALL have port Livre, output, 1, lot free and gate clear; registered.
REQ-008 SHALL have port Pare, output, 1, stop indication; registered.
REQ-009 SHALL have port Erro, output, 1, sequence violation indication; registered.
REQ-010 SHALL have port Full, output, 1, lot at capacity; registered.
REQ-011 SHALL have port Contagem, output, 4, current vehicle count, unsigned; registered.

Function
REQ-012 SHALL pass each sensor through a 2-flop synchronizer before any other use.
REQ-013 SHALL debounce each synchronized sensor: a per-sensor counter increments while synchronized != debounced level, clears when equal; debounced level takes the synchronized value on the edge where the counter equals FILTRO-1, counter then clears.
REQ-014 SHALL ignore any synchronized level change lasting fewer than FILTRO cycles.
REQ-015 SHALL generate a one-cycle event on each rising edge of a debounced sensor (entry event, exit event); falling edges generate no event.
REQ-016 SHALL, for a raw level held stable from before edge N, update Contagem and state on edge N+FILTRO+2.
REQ-017 SHALL implement states OCIOSO, PASSAGEM, LOTADO, ERRO.
REQ-018 SHALL on entry event only: if Contagem < CAPACIDADE increment Contagem, else enter ERRO with Contagem unchanged.
REQ-019 SHALL on exit event only: if Contagem > 0 decrement Contagem, else enter ERRO with Contagem unchanged.
REQ-020 SHALL on simultaneous entry and exit events leave Contagem unchanged and raise no error.
REQ-021 SHALL remain in ERRO, ignoring count updates, until both debounced sensors are low; then leave ERRO on that edge.
REQ-022 SHALL, outside ERRO, select next state by priority: new Contagem == CAPACIDADE -> LOTADO; debounced entry high -> PASSAGEM; else OCIOSO.
REQ-023 SHALL drive outputs per state: OCIOSO Livre=1 others 0; PASSAGEM Pare=1 others 0; LOTADO Pare=1 Full=1 others 0; ERRO Pare=1 Erro=1 others 0.
REQ-024 SHALL never wrap Contagem below 0 or above CAPACIDADE.

Reset
REQ-025 SHALL on Reset high at an edge set Contagem=0, state OCIOSO (Livre=1, Pare=0, Erro=0, Full=0), clear synchronizers, debounced levels, debounce counters and event registers.
REQ-026 SHALL have Reset take priority over all events in the same cycle; partial debounce progress is discarded.
REQ-027 SHALL, after Reset deasserts, require a full FILTRO-cycle stable period before any event.

Verification (CAPACIDADE=3, FILTRO=3)
REQ-028 SHALL cover: Reset 2 cycles -> Livre=1, Pare=0, Erro=0, Full=0, Contagem=0.
REQ-029 SHALL cover: SensorEntrada high 10 cycles from edge N -> Contagem=1 and Pare=1, Livre=0 after edge N+5; after release plus 5 cycles -> Livre=1, Contagem=1.
REQ-030 SHALL cover: SensorEntrada high 2 cycles only -> no change to any output.
REQ-031 SHALL cover: three separated entries -> Contagem=3, Full=1, Pare=1; fourth entry -> Erro=1, Full=0, Contagem=3; sensors low -> LOTADO, Full=1, Erro=0.
REQ-032 SHALL cover: exit at Contagem=0 -> Erro=1, Contagem=0; at Contagem=1, both sensors rising on same cycle -> Contagem=1, Erro=0.
REQ-033 SHALL cover: Reset asserted 2 cycles into a held entry pulse -> Contagem=0, Livre=1, no increment until sensor released and re-asserted.
